// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI register responder
// Purpose: FSM state type, command-byte layout and byte width used by the
//          responder top level.
// Ports:   none (package)
package spi_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_rsp_state_t;

  // Bit of the command byte that selects read (1) or write (0).
  localparam int CMD_RW_BIT = 7;
  localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
// Purpose: brings one asynchronous SPI pin into the clk domain and flags its
//          edges by comparing the last two synchronized samples.
// Ports:   clk, rst_n  - system clock, async active-low reset
//          din         - asynchronous pin
//          q           - synchronized level
//          rise, fall  - 1-clk pulses on synchronized edges
module spi_sync_edge #(
  parameter int   SYNC_FF = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] sync_r;
  logic               q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_FF{RST_VAL}};
      q_d    <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_FF-2:0], din};
      q_d    <= sync_r[SYNC_FF-1];
    end
  end

  assign q    = sync_r[SYNC_FF-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 responder with byte-wide register bank
// Purpose: decodes {rw, addr} command byte, then streams data bytes with an
//          auto-incrementing, wrapping address; fabric sees the whole bank,
//          a write-notify strobe and has its own local write port.
// Ports:   clk, rst_n               - system clock, async active-low reset
//          ss_n, sclk, mosi         - SPI pins (asynchronous)
//          miso, miso_tri           - serial out, tri-state request
//          regs_q                   - flattened bank, byte i at [8i+7:8i]
//          wr_stb, wr_addr, wr_data - SPI write notification
//          lw_en, lw_addr, lw_data  - fabric local write port
//          busy                     - transaction selected
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int SYNC_FF = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ss_n,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_tri,
  output logic [8*NREG-1:0]       regs_q,
  output logic                    wr_stb,
  output logic [$clog2(NREG)-1:0] wr_addr,
  output logic [7:0]              wr_data,
  input  logic                    lw_en,
  input  logic [$clog2(NREG)-1:0] lw_addr,
  input  logic [7:0]              lw_data,
  output logic                    busy
);

  localparam int AW = $clog2(NREG);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .din(ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the sclk edges and the mosi level matter to the protocol.
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_s, mosi_rise, mosi_fall};

  spi_rsp_state_t          state;
  logic [2:0]              bit_cnt;
  logic [SPI_BYTE_W-1:0]   rx_sr;
  logic [SPI_BYTE_W-1:0]   tx_sr;
  logic [AW-1:0]           addr;
  logic                    rw;
  logic [SPI_BYTE_W-1:0]   regs [NREG];

  logic [SPI_BYTE_W-1:0]   rx_next;
  logic                    byte_done;
  logic [AW-1:0]           cmd_addr;
  logic [AW-1:0]           addr_inc;
  logic                    spi_commit;

  assign rx_next   = {rx_sr[SPI_BYTE_W-2:0], mosi_s};
  assign byte_done = (bit_cnt == 3'd7);
  assign cmd_addr  = rx_next[AW-1:0];
  assign addr_inc  = addr + AW'(1);

  // A deselect in the same clk as the last rising edge discards the byte.
  assign spi_commit = (state == DATA) && !rw && sclk_rise && byte_done && !ss_rise;

  assign busy     = ~ss_s;
  assign miso_tri = ss_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      addr    <= '0;
      rw      <= 1'b0;
      miso    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (ss_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ss_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD, DATA: begin
            if (sclk_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (state == CMD) begin
                  state <= DATA;
                  rw    <= rx_next[CMD_RW_BIT];
                  addr  <= cmd_addr;
                  // Preloaded even for writes; never shifted out unless rw.
                  tx_sr <= regs[cmd_addr];
                end else begin
                  addr <= addr_inc;
                  if (rw) begin
                    tx_sr <= regs[addr_inc];
                  end else begin
                    wr_stb  <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= rx_next;
                  end
                end
              end
            end else if (sclk_fall && (state == DATA) && rw) begin
              // First fall after a load presents bit7; later falls shift.
              miso  <= tx_sr[SPI_BYTE_W-1];
              tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Local write first so a same-address SPI commit overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (lw_en)      regs[lw_addr] <= lw_data;
      if (spi_commit) regs[addr]    <= rx_next;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_q[8*g +: 8] = regs[g];
  end

endmodule
